io_bridge: RTL and testbench

IO_BRIDGE -- requirements
Module: io_bridge

---
 rtl/io_bridge.sv | 128 ++++++++++++
 tb/tb_io_bridge.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/io_bridge.sv
// io_bridge: CPU bus bridge; zero-wait memory port plus a wait-stated I/O handshake port on page IO_PAGE.
// Ports:
//   clk, RST                  clock, asynchronous active-high reset
//   AB, DO, WE / DI, RDY      CPU address, write data, write enable / read data, ready (0 stalls CPU)
//   mem_AB, mem_DO, mem_WE    zero-wait memory port outputs; mem_DI memory read data
//   io_AB, io_DO, io_WE       latched I/O access; io_req/io_ack handshake; io_DI I/O read data
//   bus_err                   one-cycle pulse when an I/O access is aborted by timeout
// Optional feature: define IO_BRIDGE_TIMEOUT_EN to abort REQ after TIMEOUT cycles without io_ack.
module io_bridge #(
    parameter logic [7:0]  IO_PAGE = 8'hFE,
    parameter int unsigned IO_WAIT = 2,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        RST,
    input  logic [15:0] AB,
    input  logic [7:0]  DO,
    input  logic        WE,
    output logic [7:0]  DI,
    output logic        RDY,
    output logic [15:0] mem_AB,
    output logic [7:0]  mem_DO,
    output logic        mem_WE,
    input  logic [7:0]  mem_DI,
    output logic [7:0]  io_AB,
    output logic [7:0]  io_DO,
    output logic        io_WE,
    output logic        io_req,
    input  logic        io_ack,
    input  logic [7:0]  io_DI,
    output logic        bus_err
);
    typedef enum logic [1:0] {IDLE, WAIT, REQ, DONE} state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] hold_q, hold_d;
    logic [7:0] io_ab_q, io_ab_d;
    logic [7:0] io_do_q, io_do_d;
    logic       io_we_q, io_we_d;
    logic       io_sel;
    logic       start;
    logic       timeout;

    assign io_sel = (AB[15:8] == IO_PAGE);
    assign start  = (state_q == IDLE) && io_sel;

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            hold_q  <= 8'h00;
            io_ab_q <= 8'h00;
            io_do_q <= 8'h00;
            io_we_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            io_ab_q <= io_ab_d;
            io_do_q <= io_do_d;
            io_we_q <= io_we_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = io_sel ? WAIT : IDLE;
            WAIT:    state_d = (cnt_q == 4'd0) ? REQ : WAIT;
            REQ:     state_d = (io_ack || timeout) ? DONE : REQ;
            default: state_d = IDLE;
        endcase
    end

    // The I/O access is captured once in IDLE so the CPU side may change freely until DONE.
    always_comb begin
        cnt_d   = start ? 4'(IO_WAIT) : (state_q == WAIT && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
        io_ab_d = start ? AB[7:0] : io_ab_q;
        io_do_d = start ? DO : io_do_q;
        io_we_d = start ? WE : io_we_q;
        hold_d  = timeout ? 8'hFF : (state_q == REQ && io_ack && !io_we_q) ? io_DI : hold_q;
    end

    // RDY is forced high during reset even if AB still points at the I/O page.
    always_comb begin
        io_req = (state_q == REQ);
        RDY    = RST || (state_q == IDLE && !io_sel) || (state_q == DONE);
        DI     = (state_q == DONE) ? hold_q : mem_DI;
        mem_WE = WE && !io_sel && (state_q == IDLE);
    end

    assign mem_AB = AB;
    assign mem_DO = DO;
    assign io_AB  = io_ab_q;
    assign io_DO  = io_do_q;
    assign io_WE  = io_we_q;

`ifdef IO_BRIDGE_TIMEOUT_EN
    logic [7:0] tmo_q, tmo_d;
    logic       bus_err_q, bus_err_d;

    // tmo_q counts completed REQ cycles; it sits at 0 outside REQ so entry always starts from 0.
    always_comb begin
        tmo_d     = (state_q == REQ) ? tmo_q + 8'd1 : 8'd0;
        timeout   = (state_q == REQ) && !io_ack && (tmo_q == 8'(TIMEOUT - 1));
        bus_err_d = timeout;
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            tmo_q     <= 8'd0;
            bus_err_q <= 1'b0;
        end else begin
            tmo_q     <= tmo_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign bus_err = bus_err_q;
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT;
    assign timeout        = 1'b0;
    assign bus_err        = 1'b0;
`endif
endmodule

// File: tb/tb_io_bridge.sv
// tb_io_bridge: randomized scoreboard bench for io_bridge against a per-access latency/data model.
module tb_io_bridge;
    localparam int IO_WAIT = 2;
`ifdef IO_BRIDGE_TIMEOUT_EN
    localparam int TMO    = 4;
    localparam bit TMO_EN = 1'b1;
`else
    localparam int TMO    = 255;
    localparam bit TMO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] AB = 16'h0000;
    logic [7:0]  DO = 8'h00;
    logic        WE = 1'b0;
    logic [7:0]  mem_DI = 8'h00;
    logic        io_ack = 1'b0;
    logic [7:0]  io_DI = 8'h00;
    logic [7:0]  DI, io_AB, io_DO, mem_DO;
    logic [15:0] mem_AB;
    logic        RDY, mem_WE, io_WE, io_req, bus_err;

    io_bridge #(.IO_PAGE(8'hFE), .IO_WAIT(IO_WAIT), .TIMEOUT(TMO)) dut (
        .clk(clk), .RST(RST), .AB(AB), .DO(DO), .WE(WE), .DI(DI), .RDY(RDY),
        .mem_AB(mem_AB), .mem_DO(mem_DO), .mem_WE(mem_WE), .mem_DI(mem_DI),
        .io_AB(io_AB), .io_DO(io_DO), .io_WE(io_WE), .io_req(io_req),
        .io_ack(io_ack), .io_DI(io_DI), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         io;
        bit         we;
        logic [7:0] di;
        int         low;
        int         req;
        int         mwe;
        int         berr;
        logic [7:0] ab;
        logic [7:0] dout;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       e;
    int         tests = 0;
    int         fails = 0;
    int         ack_delay = 0;
    int         rcnt = 0;
    logic [7:0] io_val = 8'h00;
    logic [7:0] last_io = 8'h00;
    int         lowc = 0, reqc = 0, mwec = 0, berrc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // I/O device: acks on REQ cycle ack_delay+1, and toggles io_ack randomly when not requested.
    always @(negedge clk) begin
        if (io_req) begin
            io_ack = (rcnt == ack_delay);
            io_DI  = io_ack ? io_val : 8'($urandom);
            rcnt++;
        end else begin
            rcnt   = 0;
            io_ack = 1'($urandom_range(0, 1));
            io_DI  = 8'($urandom);
        end
    end

    // Monitor: accumulates per-access observations and scores them when RDY completes the access.
    always @(negedge clk) begin
        if (RST) begin
            exp_q.delete();
            lowc = 0; reqc = 0; mwec = 0; berrc = 0;
        end else if (exp_q.size() != 0) begin
            lowc  += RDY ? 0 : 1;
            reqc  += io_req ? 1 : 0;
            mwec  += mem_WE ? 1 : 0;
            berrc += bus_err ? 1 : 0;
            if (RDY) begin
                e = exp_q.pop_front();
                check("rdy_low_cycles", 32'(lowc), 32'(e.low));
                check("di", 32'(DI), 32'(e.di));
                check("io_req_cycles", 32'(reqc), 32'(e.req));
                check("mem_we_cycles", 32'(mwec), 32'(e.mwe));
                check("bus_err_pulses", 32'(berrc), 32'(e.berr));
                if (e.io) begin
                    check("io_ab", 32'(io_AB), 32'(e.ab));
                    check("io_do", 32'(io_DO), 32'(e.dout));
                    check("io_we", 32'(io_WE), 32'(e.we));
                end
                lowc = 0; reqc = 0; mwec = 0; berrc = 0;
            end
        end
    end

    task automatic issue(input bit io, input bit we, input logic [15:0] ab, input logic [7:0] dout,
                         input logic [7:0] mdi, input logic [7:0] iodi, input int d, input bit scram);
        exp_t x;
        bit   to;
        int   i;
        to     = TMO_EN && io && d >= TMO;
        x.io   = io;
        x.we   = we;
        x.ab   = ab[7:0];
        x.dout = dout;
        x.di   = !io ? mdi : to ? 8'hFF : we ? last_io : iodi;
        x.low  = !io ? 0 : to ? IO_WAIT + 2 + TMO : IO_WAIT + 3 + d;
        x.req  = !io ? 0 : to ? TMO : d + 1;
        x.mwe  = (!io && we) ? 1 : 0;
        x.berr = to ? 1 : 0;
        if (io) last_io = to ? 8'hFF : we ? last_io : iodi;
        ack_delay = d;
        io_val    = iodi;
        AB        = ab;
        DO        = dout;
        WE        = we;
        mem_DI    = mdi;
        exp_q.push_back(x);
        i = 0;
        while (1) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) break;
            if (i >= 300) begin
                tests++;
                fails++;
                $display("FAIL access_done: actual no RDY after %0d cycles required completion", i);
                exp_q.delete();
                break;
            end
            if (scram) begin
                DO      = 8'($urandom);
                WE      = 1'($urandom);
                AB[7:0] = 8'($urandom);
            end
            i++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual still running required finish");
        $fatal(1);
    end

    initial begin
        logic [1:0]  k;
        logic [15:0] ab;
        bit          seen;
        AB     = 16'hFE00;
        WE     = 1'b1;
        mem_DI = 8'h3E;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rdy", 32'(RDY), 32'd1);
        check("reset_io_req", 32'(io_req), 32'd0);
        check("reset_bus_err", 32'(bus_err), 32'd0);
        check("reset_io_ab", 32'(io_AB), 32'h00);
        check("reset_io_do", 32'(io_DO), 32'h00);
        check("reset_io_we", 32'(io_WE), 32'd0);
        check("reset_di", 32'(DI), 32'h3E);
        AB  = 16'h0000;
        WE  = 1'b0;
        RST = 1'b0;

        issue(1'b0, 1'b0, 16'h1234, 8'h00, 8'h5A, 8'h00, 0, 1'b0);
        issue(1'b1, 1'b0, 16'hFE10, 8'h00, 8'h00, 8'hC3, 0, 1'b0);
        issue(1'b1, 1'b1, 16'hFE20, 8'h77, 8'h00, 8'h00, 1, 1'b1);
        issue(1'b0, 1'b1, 16'h2000, 8'h99, 8'h11, 8'h00, 0, 1'b0);

        for (int n = 0; n < 80; n++) begin
            k  = 2'($urandom_range(0, 3));
            ab = 16'($urandom);
            if (k[1]) ab[15:8] = 8'hFE;
            else if (ab[15:8] == 8'hFE) ab[15:8] = 8'h00;
            issue(k[1], k[0], ab, 8'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 3), 1'b1);
        end

`ifdef IO_BRIDGE_TIMEOUT_EN
        issue(1'b1, 1'b0, 16'hFE55, 8'h00, 8'h00, 8'h12, TMO + 3, 1'b0);
        issue(1'b1, 1'b0, 16'hFE56, 8'h00, 8'h00, 8'h34, TMO - 1, 1'b0);
`endif

        AB        = 16'hFE40;
        WE        = 1'b0;
        ack_delay = 1000;
        seen      = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = io_req;
        end
        check("reach_req", 32'(seen), 32'd1);
        @(posedge clk);
        #1 RST = 1'b1;
        #1;
        check("midrst_io_req", 32'(io_req), 32'd0);
        check("midrst_rdy", 32'(RDY), 32'd1);
        check("midrst_io_ab", 32'(io_AB), 32'h00);
        repeat (2) @(posedge clk);
        #1;
        AB      = 16'h0042;
        RST     = 1'b0;
        last_io = 8'h00;
        issue(1'b0, 1'b0, 16'h0042, 8'h00, 8'hA5, 8'h00, 0, 1'b0);
        issue(1'b1, 1'b1, 16'hFE99, 8'h3C, 8'h00, 8'h00, 0, 1'b1);

        AB = 16'h0000;
        WE = 1'b0;
        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
